// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and default sizes for the timer sequencer
package timer_pkg;

    localparam int TIMER_PW    = 16;
    localparam int TIMER_DEPTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_ACK  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/timer_seq_table.sv
// rtl/timer_seq_table.sv - period table: one write port, one combinational read port, sync clear
module timer_seq_table
    import timer_pkg::*;
#(
    parameter int DEPTH = TIMER_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int PW    = TIMER_PW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [PW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [PW-1:0] o_rd_data
);

    logic [PW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/timer_seq_ctrl.sv
// rtl/timer_seq_ctrl.sv - one-shot step sequencer for a timer_core channel
// Optional stall watchdog enabled by defining TIMER_SEQ_WDT_EN.
module timer_seq_ctrl
    import timer_pkg::*;
#(
    parameter int          DEPTH       = TIMER_DEPTH,
    parameter int          AW          = $clog2(DEPTH),
    parameter int          PW          = TIMER_PW,
    parameter int          WDT_W       = 20,
    parameter int unsigned TIMEOUT_CYC = 70000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [PW-1:0] i_wr_data,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_loop,
    input  logic [AW:0]   i_len,
    input  logic          i_timer_irq,
    output logic          o_timer_core_en,
    output logic          o_cont,
    output logic          o_irq_clear,
    output logic [PW-1:0] o_period,
    output logic          o_busy,
    output logic [AW-1:0] o_step_idx,
    output logic          o_step_irq,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEN   = (AW+1)'(1);

    seq_state_t    state;
    logic          load_cnt;
    logic [AW-1:0] step;
    logic [AW:0]   len_q;
    logic          loop_q;
    logic          last_step;
    logic          start_acc;
    logic          wdt_trip;
    logic [AW-1:0] ld_step;
    logic [PW-1:0] rd_data;

    assign last_step = ({1'b0, step} == (len_q - ONE_LEN));
    assign start_acc = (state == ST_IDLE) && i_start && (i_len != '0) && !i_stop;

    // Table index for the next LOAD: step 0 on start or wrap, otherwise the following step.
    always_comb begin
        ld_step = step + AW'(1);
        if (state == ST_IDLE || last_step) begin
            ld_step = '0;
        end
    end

    timer_seq_table #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_table (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (ld_step),
        .o_rd_data (rd_data)
    );

`ifdef TIMER_SEQ_WDT_EN
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYC - 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             err_q;

    assign wdt_trip = (state == ST_RUN) && !i_timer_irq && (wdt_cnt == WDT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdt_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            wdt_cnt <= (state == ST_RUN) ? wdt_cnt + WDT_W'(1) : '0;
            if (start_acc) begin
                err_q <= 1'b0;
            end else if (wdt_trip && !i_stop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_err = err_q;
`else
    assign wdt_trip = 1'b0;
    assign o_err    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            load_cnt        <= 1'b0;
            step            <= '0;
            len_q           <= '0;
            loop_q          <= 1'b0;
            o_period        <= '0;
            o_timer_core_en <= 1'b0;
            o_irq_clear     <= 1'b1;
            o_step_irq      <= 1'b0;
            o_done          <= 1'b0;
        end else if (i_stop) begin
            state           <= ST_IDLE;
            o_timer_core_en <= 1'b0;
            o_irq_clear     <= 1'b1;
            o_step_irq      <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            o_irq_clear <= 1'b1;
            o_step_irq  <= 1'b0;
            o_done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_timer_core_en <= 1'b0;
                    if (start_acc) begin
                        len_q    <= (i_len > DEPTH_LEN) ? DEPTH_LEN : i_len;
                        loop_q   <= i_loop;
                        step     <= '0;
                        o_period <= rd_data;
                        load_cnt <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                // Second LOAD cycle gives the core time to capture the new period.
                ST_LOAD: begin
                    o_timer_core_en <= 1'b0;
                    if (load_cnt) begin
                        o_timer_core_en <= 1'b1;
                        state           <= ST_RUN;
                    end else begin
                        load_cnt <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_timer_irq) begin
                        o_timer_core_en <= 1'b0;
                        o_irq_clear     <= 1'b0;
                        o_step_irq      <= 1'b1;
                        state           <= ST_ACK;
                    end else if (wdt_trip) begin
                        o_timer_core_en <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    o_timer_core_en <= 1'b0;
                    if (last_step && !loop_q) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        step     <= ld_step;
                        o_period <= rd_data;
                        load_cnt <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    o_timer_core_en <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: begin
                    o_timer_core_en <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cont     = 1'b0;
    assign o_busy     = (state != ST_IDLE);
    assign o_step_idx = step;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb/tb_timer_seq_ctrl.sv - randomized self-checking bench for timer_seq_ctrl
module tb_timer_seq_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int PW    = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_wr_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [PW-1:0] i_wr_data = '0;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic          i_loop = 1'b0;
    logic [AW:0]   i_len = '0;
    logic          i_timer_irq = 1'b0;
    logic          o_timer_core_en;
    logic          o_cont;
    logic          o_irq_clear;
    logic [PW-1:0] o_period;
    logic          o_busy;
    logic [AW-1:0] o_step_idx;
    logic          o_step_irq;
    logic          o_done;
    logic          o_err;

    int n_checks = 0;
    int n_errors = 0;
    int tbl [DEPTH];

    timer_seq_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .PW(PW), .WDT_W(20), .TIMEOUT_CYC(50)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wr_en         (i_wr_en),
        .i_wr_addr       (i_wr_addr),
        .i_wr_data       (i_wr_data),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .i_loop          (i_loop),
        .i_len           (i_len),
        .i_timer_irq     (i_timer_irq),
        .o_timer_core_en (o_timer_core_en),
        .o_cont          (o_cont),
        .o_irq_clear     (o_irq_clear),
        .o_period        (o_period),
        .o_busy          (o_busy),
        .o_step_idx      (o_step_idx),
        .o_step_irq      (o_step_irq),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
    endtask

    task automatic write_tbl(input int addr, input int val);
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(addr);
        i_wr_data = PW'(val);
        tick();
        i_wr_en = 1'b0;
        tbl[addr] = val;
    endtask

    // Bench plays the timer core: irq rises once the enabled count exceeds the period.
    task automatic run_seq(input int len, input bit lp, input int stop_after, input int wr_val);
        int  eff;
        int  exp_step = 0;
        int  steps = 0;
        int  en_cnt = 0;
        int  c = 1;
        int  done_at = -1;
        bit  first_en = 0;
        bit  wrote = 0;
        bit  stopping = 0;
        bit  after_done = 0;
        bit  fin = 0;
        eff = (len > DEPTH) ? DEPTH : len;
        i_len   = (AW+1)'(len);
        i_loop  = lp;
        i_start = 1'b1;
        tick();
        while (!fin) begin
            i_start = 1'b0;
            i_wr_en = 1'b0;
            if (stopping) begin
                check("stop_busy", o_busy, 0);
                check("stop_en", o_timer_core_en, 0);
                check("stop_step_irq", o_step_irq, 0);
                check("stop_done", o_done, 0);
                i_stop = 1'b0;
                fin = 1;
            end else if (after_done) begin
                check("busy_after_done", o_busy, 0);
                fin = 1;
            end else begin
                if (c == 1) begin
                    check("period_latency", o_period, tbl[0]);
                    check("busy_start", o_busy, 1);
                    check("cont", o_cont, 0);
                    check("err_after_start", o_err, 0);
                end
                if (o_timer_core_en && !first_en) begin
                    first_en = 1;
                    check("en_latency", c, 3);
                end
                check("irq_clear", o_irq_clear, !o_step_irq);
                if (o_timer_core_en) en_cnt++;
                if (o_step_irq) begin
                    check("step_idx", o_step_idx, exp_step);
                    check("step_period", o_period, tbl[exp_step]);
                    check("run_cycles", en_cnt, tbl[exp_step] + 1);
                    en_cnt = 0;
                    steps++;
                    if (exp_step == eff - 1) begin
                        exp_step = 0;
                        if (!lp) done_at = c + 1;
                    end else begin
                        exp_step++;
                    end
                end
                if (o_done) begin
                    check("done_cycle", c, done_at);
                    after_done = 1;
                end
                if (c == 4) begin
                    i_start = 1'b1;
                    i_len   = (AW+1)'(1);
                    i_loop  = 1'b0;
                end
                if (wr_val >= 0 && !wrote && steps == 0 && o_timer_core_en) begin
                    i_wr_en   = 1'b1;
                    i_wr_addr = AW'(1);
                    i_wr_data = PW'(wr_val);
                    tbl[1]    = wr_val;
                    wrote     = 1;
                end
                if (lp && steps >= stop_after && o_timer_core_en) begin
                    i_stop   = 1'b1;
                    stopping = 1;
                end
                if (c > 3000) begin
                    check("timeout", c, 0);
                    fin = 1;
                end
            end
            i_timer_irq = o_timer_core_en && (en_cnt > int'(o_period)) && !stopping;
            if (!fin) begin
                tick();
                c++;
            end
        end
        i_timer_irq = 1'b0;
        i_start     = 1'b0;
        i_wr_en     = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_busy", o_busy, 0);
        check("rst_period", o_period, 0);
        check("rst_step_idx", o_step_idx, 0);
        check("rst_en", o_timer_core_en, 0);
        check("rst_irq_clear", o_irq_clear, 1);
        check("rst_step_irq", o_step_irq, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);

        // Unwritten table after reset: zero periods.
        run_seq(3, 1'b0, 0, -1);

        write_tbl(0, 3);
        write_tbl(1, 5);
        run_seq(2, 1'b0, 0, -1);
        run_seq(2, 1'b1, 5, -1);

        i_len = '0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len0_idle", o_busy, 0);
            tick();
        end

        for (int i = 0; i < DEPTH; i++) write_tbl(i, $urandom_range(0, 6));
        run_seq(12, 1'b0, 0, -1);

        write_tbl(0, 0);
        run_seq(3, 1'b0, 0, -1);

        write_tbl(0, 4);
        run_seq(2, 1'b0, 0, 9);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) write_tbl(i, $urandom_range(0, 6));
            run_seq($urandom_range(1, 12), 1'($urandom_range(0, 1)), $urandom_range(2, 10), -1);
        end

        write_tbl(0, 20);
        i_len = (AW+1)'(2);
        i_loop = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < 20 && !o_timer_core_en; i++) tick();
        check("en_before_rst", o_timer_core_en, 1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) tbl[i] = 0;
        check("rrst_busy", o_busy, 0);
        check("rrst_period", o_period, 0);
        check("rrst_step_idx", o_step_idx, 0);
        check("rrst_en", o_timer_core_en, 0);
        check("rrst_irq_clear", o_irq_clear, 1);
        check("rrst_step_irq", o_step_irq, 0);
        check("rrst_done", o_done, 0);
        run_seq(2, 1'b0, 0, -1);

`ifdef TIMER_SEQ_WDT_EN
        begin
            int en_cycles = 0;
            int dones = 0;
            write_tbl(0, 3);
            i_len = (AW+1)'(1);
            i_start = 1'b1;
            tick();
            i_start = 1'b0;
            for (int i = 0; i < 200 && o_busy; i++) begin
                if (o_timer_core_en) en_cycles++;
                if (o_done) dones++;
                tick();
            end
            check("wdt_run_cycles", en_cycles, 50);
            check("wdt_err", o_err, 1);
            check("wdt_idle", o_busy, 0);
            check("wdt_no_done", dones, 0);
            run_seq(1, 1'b0, 0, -1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
Sequencer for one timer_core channel. Holds a small table of periods, programs the core one step at a time in one-shot mode and acknowledges each interrupt. Advances through the table, then stops or loops. Sits between the register block (table and control writes) and timer_core (en/cont/irq_clear/period), all on the divided clock.

Parameters:
DEPTH, 8, number of period table entries (power of 2, >=2)
AW, $clog2(DEPTH), table address width
PW, 16, period width; must match timer_core i_period
WDT_W, 20, width of the optional stall watchdog counter
TIMEOUT_CYC, 20'd70000, RUN-state cycle limit used by the optional watchdog

Ports:
i_clk  in  1  divided clock
i_rst  in  1  reset, synchronous, active-high
i_wr_en  in  1  write table[i_wr_addr] <= i_wr_data
i_wr_addr  in  AW  table write address
i_wr_data  in  PW  period value
i_start  in  1  start sequence (sampled only in IDLE)
i_stop  in  1  abort; highest priority
i_loop  in  1  1: wrap to step 0 after last step; sampled at start
i_len  in  AW+1  number of steps; sampled at start
i_timer_irq  in  1  from timer_core o_irq
o_timer_core_en  out  1  to timer_core i_timer_core_en
o_cont  out  1  to timer_core i_cont; constant 0 (one-shot)
o_irq_clear  out  1  to timer_core i_irq_clear; active-low clear
o_period  out  PW  to timer_core i_period; registered
o_busy  out  1  state != IDLE
o_step_idx  out  AW  current step
o_step_irq  out  1  1-cycle pulse per completed step
o_done  out  1  1-cycle pulse when a non-loop sequence ends
o_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE; all table entries 0; o_period 0; o_step_idx 0; o_timer_core_en 0; o_irq_clear 1; o_step_irq, o_done and o_err 0. Latched len 0; latched loop 0.
- Table writes are accepted in any state. A write to the active step takes effect at that step's next LOAD.
- States: IDLE, LOAD, RUN, ACK, DONE.
- IDLE: en=0, clear=1.
  - On i_start with i_len!=0: latch len = min(i_len, DEPTH), latch loop, step=0, go to LOAD.
  - i_start with i_len==0 is ignored.
- LOAD (exactly 2 cycles): en=0.
  - o_period <= table[step] at LOAD entry.
  - The second cycle lets the core's internal period register settle.
  - Latency: i_start sampled at edge k -> o_period valid from k+1 -> o_timer_core_en=1 from k+3.
- RUN: en=1. On i_timer_irq==1, go to ACK.
- ACK (1 cycle): en=0, o_irq_clear=0, o_step_irq=1.
  - If step==len-1 and loop=1: step=0, go to LOAD.
  - If step==len-1 and loop=0: go to DONE.
  - Otherwise: step+1, go to LOAD.
- DONE (1 cycle): o_done=1, then IDLE.
- i_stop in any state: next state IDLE, en=0. No o_done and no o_step_irq. i_stop wins over a simultaneous irq or start.
- Period 0 is legal: the core fires on the first enabled cycle and the step completes normally.
- i_start while busy is ignored. i_len and i_loop changes while busy are ignored.
- The o_err sticky bit is cleared only by i_rst or by an accepted i_start.

Optional Feature:
TIMER_SEQ_WDT_EN
- Defined: a WDT_W counter clears on RUN entry and increments each RUN cycle.
- If it reaches TIMEOUT_CYC without an irq: o_err=1, go to IDLE (en=0), no o_done.
- Not defined: no counter; o_err tied 0.

Decomposition:
- Package timer_pkg: state encoding constants (IDLE/LOAD/RUN/ACK/DONE), PW=16 and the default DEPTH.
- Sub-module timer_seq_table: DEPTH x PW register file with sync-reset clear, one write port and one combinational read port.
- FSM and watchdog stay in timer_seq_ctrl.

Test Plan:
1. Table = {3,5}, len=2, loop=0, start -> two o_step_irq pulses and one o_done. o_period is 3 then 5. o_busy drops the cycle after o_done.
2. Same table, loop=1 -> step_idx runs 0,1,0,1… with no o_done. i_stop during RUN -> IDLE next cycle, en=0, no pulses.
3. i_len=0 start -> stays IDLE. i_len=12 with DEPTH=8 -> 8 steps then o_done.
4. Period 0 at step 0 -> irq on the first RUN cycle, ACK drives o_irq_clear=0 for 1 cycle, sequence advances.
5. Write table[1]=9 while step 0 is RUN -> step 1 loads 9. Assert i_rst in RUN -> all outputs at reset values next cycle.
6. With TIMER_SEQ_WDT_EN, TIMEOUT_CYC=50 and i_timer_irq held 0 -> o_err=1 after 50 RUN cycles, IDLE. The next accepted start clears o_err.
